// File: rtl/tm1637_frame_if.sv
// Bundle between the TM1637 frame sequencer, its requester and the byte-level bus driver.
interface tm1637_frame_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    update;
   logic [8*NUM_DIGITS-1:0] digits;
   logic [2:0]              brightness;
   logic                    display_on;
   logic                    busy;
   logic                    frame_done;
   logic                    tm_latch;
   logic [7:0]              tm_byte;
   logic                    tm_stop;
   logic                    tm_busy;

   modport slave (
      input  update, digits, brightness, display_on, tm_busy,
      output busy, frame_done, tm_latch, tm_byte, tm_stop
   );

   modport master (
      output update, digits, brightness, display_on, tm_busy,
      input  busy, frame_done, tm_latch, tm_byte, tm_stop
   );
endinterface

// File: rtl/tm1637_frame_ctrl.sv
// TM1637 frame sequencer: snapshots segments/brightness and feeds one byte per driver transaction.
// Optional periodic re-send of the frame from IDLE when TM1637_AUTO_REFRESH_EN is defined.
module tm1637_frame_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_CYCLES = 600000
) (
   input  logic                 clk,
   input  logic                 rst,
   tm1637_frame_if.slave        bus
);

   // state  | meaning
   // IDLE   | no frame; waits for update (or refresh tick)
   // LOAD   | snapshot inputs, restart byte index
   // SEND   | present table byte with a 1-cycle latch pulse
   // ACCEPT | wait for the driver to raise busy
   // DONE   | wait for the driver to drop busy
   // NEXT   | advance index or close the frame
   typedef enum logic [2:0] {IDLE, LOAD, SEND, ACCEPT, DONE, NEXT} state_t;

   localparam int LAST = NUM_DIGITS + 2;
   localparam int IW   = $clog2(NUM_DIGITS + 3);

   state_t                  r_state;
   state_t                  w_next;
   logic [8*NUM_DIGITS-1:0] r_digits;
   logic [2:0]              r_bright;
   logic                    r_disp_on;
   logic [IW-1:0]           r_idx;
   logic                    r_pending;
   logic                    r_tm_latch;
   logic [7:0]              r_tm_byte;
   logic                    r_tm_stop;

   logic                    w_last;
   logic                    w_trigger;
   logic                    w_refresh_hit;
   logic                    w_frame_done;
   logic [7:0]              w_byte;
   logic                    w_stop;

   assign w_last    = (r_idx == IW'(LAST));
   assign w_trigger = bus.update | w_refresh_hit;

`ifdef TM1637_AUTO_REFRESH_EN
   logic [31:0] r_refresh_cnt;

   assign w_refresh_hit = (r_state == IDLE) && (r_refresh_cnt == 32'(REFRESH_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_refresh_cnt <= 32'd0;
      end else if (w_next == LOAD) begin
         r_refresh_cnt <= 32'd0;
      end else if (r_state == IDLE) begin
         r_refresh_cnt <= r_refresh_cnt + 32'd1;
      end
   end
`else
   logic w_unused_refresh;

   assign w_refresh_hit    = 1'b0;
   assign w_unused_refresh = (REFRESH_CYCLES == 0);
`endif

   always_comb begin
      w_next       = r_state;
      w_frame_done = 1'b0;
      case (r_state)
         IDLE:    if (w_trigger) w_next = LOAD;
         LOAD:    w_next = SEND;
         SEND:    w_next = ACCEPT;
         ACCEPT:  if (bus.tm_busy) w_next = DONE;
         DONE:    if (!bus.tm_busy) w_next = NEXT;
         NEXT: begin
            if (w_last) begin
               w_frame_done = 1'b1;
               // an update landing on the closing cycle is honoured like a pending one
               w_next = (r_pending || bus.update) ? LOAD : IDLE;
            end else begin
               w_next = SEND;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_byte = 8'h00;
      w_stop = 1'b0;
      if (r_idx == IW'(0)) begin
         w_byte = 8'h40;
         w_stop = 1'b1;
      end else if (r_idx == IW'(1)) begin
         w_byte = 8'hC0;
         w_stop = 1'b0;
      end else if (r_idx == IW'(LAST)) begin
         w_byte = {4'b1000, r_disp_on, r_bright};
         w_stop = 1'b1;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IW'(i + 2)) begin
               w_byte = r_digits[8*i +: 8];
               w_stop = (i == NUM_DIGITS - 1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_digits   <= '0;
         r_bright   <= 3'd0;
         r_disp_on  <= 1'b0;
         r_idx      <= '0;
         r_pending  <= 1'b0;
         r_tm_latch <= 1'b0;
         r_tm_byte  <= 8'h00;
         r_tm_stop  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_tm_latch <= (r_state == SEND);

         if (r_state == SEND) begin
            r_tm_byte <= w_byte;
            r_tm_stop <= w_stop;
         end

         if (r_state == LOAD) begin
            r_digits  <= bus.digits;
            r_bright  <= bus.brightness;
            r_disp_on <= bus.display_on;
            r_idx     <= '0;
         end else if (r_state == NEXT && !w_last) begin
            r_idx <= r_idx + IW'(1);
         end

         if (w_next == LOAD) begin
            r_pending <= 1'b0;
         end else if (bus.update && r_state != IDLE) begin
            r_pending <= 1'b1;
         end
      end
   end

   assign bus.busy       = (r_state != IDLE);
   assign bus.frame_done = w_frame_done;
   assign bus.tm_latch   = r_tm_latch;
   assign bus.tm_byte    = r_tm_byte;
   assign bus.tm_stop    = r_tm_stop;

endmodule
